// File: rtl/knn_pkg.sv
// Shared definitions for the KNN peripheral: default geometry, the result
// reader's state encoding and its CPU register map.
package knn_pkg;

    localparam int KNN_K        = 4;
    localparam int KNN_N_LABELS = 8;
    localparam int KNN_DIST_W   = 32;

    typedef enum logic [2:0] {
        KNN_RD_IDLE   = 3'd0,
        KNN_RD_CLEAR  = 3'd1,
        KNN_RD_SCAN   = 3'd2,
        KNN_RD_ARGMAX = 3'd3,
        KNN_RD_DONE   = 3'd4
    } knn_rd_state_t;

    localparam logic [1:0] KNN_RD_STATUS  = 2'd0;
    localparam logic [1:0] KNN_RD_RESULT  = 2'd1;
    localparam logic [1:0] KNN_RD_VOTES   = 2'd2;
    localparam logic [1:0] KNN_RD_NEAREST = 2'd3;

endpackage

// File: rtl/knn_vote_hist.sv
// Label histogram: one saturating vote counter per class label, with a
// synchronous clear, increment-by-label and a combinational indexed read.
module knn_vote_hist #(
    parameter int N_LABELS = 8,
    parameter int LABEL_W  = 3,
    parameter int CNT_W    = 3,
    parameter int SAT      = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               inc,
    input  logic [LABEL_W-1:0] inc_idx,
    input  logic [LABEL_W-1:0] rd_idx,
    output logic [CNT_W-1:0]   rd_cnt
);

    logic [N_LABELS*CNT_W-1:0] cnt_flat;

    for (genvar gi = 0; gi < N_LABELS; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_reg;

        // Per-label counter: clear wins, increments stop at SAT.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_reg <= '0;
            end else if (clr) begin
                cnt_reg <= '0;
            end else if (inc && (inc_idx == LABEL_W'(gi)) && (cnt_reg != CNT_W'(SAT))) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end

        assign cnt_flat[gi*CNT_W +: CNT_W] = cnt_reg;
    end

    assign rd_cnt = cnt_flat[int'(rd_idx)*CNT_W +: CNT_W];

endmodule

// File: rtl/knn_result_reader.sv
// KNN result reader: once the neighbour list is final, scans the K slots
// into a label histogram, picks the majority label (lowest label on ties)
// and serves status/result/votes/nearest distance over iob native reads.
module knn_result_reader
    import knn_pkg::*;
#(
    parameter int K        = KNN_K,
    parameter int N_LABELS = KNN_N_LABELS,
    parameter int LABEL_W  = $clog2(N_LABELS),
    parameter int DIST_W   = KNN_DIST_W,
    parameter int ADDR_W   = 2,
    localparam int IDX_W   = (K > 1) ? $clog2(K) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [IDX_W-1:0]   nb_idx,
    input  logic               nb_valid,
    input  logic [LABEL_W-1:0] nb_label,
    input  logic [DIST_W-1:0]  nb_dist,
    input  logic               valid,
    input  logic [ADDR_W-1:0]  address,
    input  logic [3:0]         wstrb,
    output logic [31:0]        rdata,
    output logic               ready,
    output logic               busy
);

    localparam int CNT_W = $clog2(K + 1);

    knn_rd_state_t state_reg, state_next;

    logic [IDX_W-1:0]   idx_reg;
    logic [LABEL_W-1:0] lbl_reg;
    logic [CNT_W-1:0]   hist_cnt;
    logic [CNT_W-1:0]   votes_reg, votes_next, votes_sh_reg;
    logic [LABEL_W-1:0] result_reg, result_next, result_sh_reg;
    logic [DIST_W-1:0]  nearest_reg, nearest_sh_reg;
    logic               done_reg, busy_reg;
    logic               clr_hist, hist_inc, take_start, finish;
    logic               scan_last, argmax_last;
    logic               rd_req, rd_result;
    logic [31:0]        rdata_next;

    assign scan_last   = (idx_reg == IDX_W'(K - 1));
    assign argmax_last = (lbl_reg == LABEL_W'(N_LABELS - 1));
    assign take_start  = start && ((state_reg == KNN_RD_IDLE) || (state_reg == KNN_RD_DONE));
    assign finish      = (state_reg == KNN_RD_ARGMAX) && argmax_last;
    assign rd_req      = valid && (wstrb == 4'h0);
    assign rd_result   = rd_req && (address == ADDR_W'(KNN_RD_RESULT));

    assign nb_idx = idx_reg;
    assign busy   = busy_reg;

    knn_vote_hist #(
        .N_LABELS (N_LABELS),
        .LABEL_W  (LABEL_W),
        .CNT_W    (CNT_W),
        .SAT      (K)
    ) u_hist (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr_hist),
        .inc     (hist_inc),
        .inc_idx (nb_label),
        .rd_idx  (lbl_reg),
        .rd_cnt  (hist_cnt)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= KNN_RD_IDLE;
        else     state_reg <= state_next;
    end

    // Next-state and histogram control; start only counts in IDLE/DONE.
    always_comb begin
        state_next = state_reg;
        clr_hist   = 1'b0;
        hist_inc   = 1'b0;
        case (state_reg)
            KNN_RD_IDLE, KNN_RD_DONE: begin
                if (start) state_next = KNN_RD_CLEAR;
            end
            KNN_RD_CLEAR: begin
                clr_hist   = 1'b1;
                state_next = KNN_RD_SCAN;
            end
            KNN_RD_SCAN: begin
                hist_inc = nb_valid;
                if (scan_last) state_next = KNN_RD_ARGMAX;
            end
            KNN_RD_ARGMAX: begin
                if (argmax_last) state_next = KNN_RD_DONE;
            end
            default: state_next = KNN_RD_IDLE;
        endcase
    end

    // Running argmax: strict compare keeps the lowest label on ties.
    always_comb begin
        votes_next  = votes_reg;
        result_next = result_reg;
        if (hist_cnt > votes_reg) begin
            votes_next  = hist_cnt;
            result_next = lbl_reg;
        end
    end

    // Slot and label counters; both return to zero after their last step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_reg <= '0;
            lbl_reg <= '0;
        end else if (state_reg == KNN_RD_CLEAR) begin
            idx_reg <= '0;
            lbl_reg <= '0;
        end else if (state_reg == KNN_RD_SCAN) begin
            idx_reg <= scan_last ? '0 : idx_reg + 1'b1;
        end else if (state_reg == KNN_RD_ARGMAX) begin
            lbl_reg <= argmax_last ? '0 : lbl_reg + 1'b1;
        end
    end

    // Working argmax/nearest registers and the CPU-visible shadow copies.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            votes_reg      <= '0;
            result_reg     <= '0;
            nearest_reg    <= '0;
            votes_sh_reg   <= '0;
            result_sh_reg  <= '0;
            nearest_sh_reg <= '0;
        end else begin
            if (state_reg == KNN_RD_CLEAR) begin
                votes_reg  <= '0;
                result_reg <= '0;
            end else if (state_reg == KNN_RD_ARGMAX) begin
                votes_reg  <= votes_next;
                result_reg <= result_next;
            end
            if ((state_reg == KNN_RD_SCAN) && (idx_reg == '0)) begin
                nearest_reg <= nb_valid ? nb_dist : '1;
            end
            if (finish) begin
                votes_sh_reg   <= votes_next;
                result_sh_reg  <= result_next;
                nearest_sh_reg <= nearest_reg;
            end
        end
    end

    // Status flags: a RESULT read clears done unless a run just finished.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else if (take_start) begin
            busy_reg <= 1'b1;
            done_reg <= 1'b0;
        end else if (finish) begin
            busy_reg <= 1'b0;
            done_reg <= 1'b1;
        end else if (rd_result) begin
            done_reg <= 1'b0;
        end
    end

    // Register-map read mux.
    always_comb begin
        rdata_next = '0;
        case (address)
            ADDR_W'(KNN_RD_STATUS):  rdata_next = 32'({busy_reg, done_reg});
            ADDR_W'(KNN_RD_RESULT):  rdata_next = 32'(result_sh_reg);
            ADDR_W'(KNN_RD_VOTES):   rdata_next = 32'(votes_sh_reg);
            ADDR_W'(KNN_RD_NEAREST): rdata_next = 32'(nearest_sh_reg);
            default:                 rdata_next = '0;
        endcase
    end

    // Registered read response: one ready pulse per read request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready <= 1'b0;
            rdata <= '0;
        end else begin
            ready <= rd_req;
            if (rd_req) rdata <= rdata_next;
        end
    end

endmodule

// File: tb/tb_knn_result_reader.sv
// Bench for knn_result_reader: table of neighbour lists with hand-derived
// majority results, read back over the bus through a scoreboard queue.
module tb_knn_result_reader;
    import knn_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, nb_valid, valid, ready, busy;
    logic [1:0]  nb_idx, address;
    logic [2:0]  nb_label;
    logic [31:0] nb_dist, rdata;
    logic [3:0]  wstrb;

    always #5 clk = ~clk;

    // Neighbour-list storage model, read combinationally by slot index.
    logic [2:0]  slot_label [4];
    logic        slot_valid [4];
    logic [31:0] slot_dist  [4];

    always_comb begin
        nb_valid = slot_valid[nb_idx];
        nb_label = slot_label[nb_idx];
        nb_dist  = slot_dist[nb_idx];
    end

    knn_result_reader dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .nb_idx   (nb_idx),
        .nb_valid (nb_valid),
        .nb_label (nb_label),
        .nb_dist  (nb_dist),
        .valid    (valid),
        .address  (address),
        .wstrb    (wstrb),
        .rdata    (rdata),
        .ready    (ready),
        .busy     (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] exp;
    } rd_exp_t;

    rd_exp_t exp_q[$];

    // Scoreboard: every ready pulse pops one expected read result.
    always @(negedge clk) begin : mon
        rd_exp_t e;
        if (ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ready", 32'(ready), 32'd0);
            end else begin
                e = exp_q.pop_front();
                $display("read addr=%0d rdata=0x%08h expected=0x%08h", e.addr, rdata, e.exp);
                check($sformatf("rdata_addr%0d", e.addr), rdata, e.exp);
            end
        end
    end

    typedef struct packed {
        logic [3:0][2:0] lbl;
        logic [3:0]      vld;
        logic [31:0]     dist0;
        logic [2:0]      exp_res;
        logic [2:0]      exp_votes;
        logic [31:0]     exp_near;
    } vec_t;

    function automatic vec_t mk(input logic [2:0] l0, l1, l2, l3, input logic [3:0] v,
                                input logic [31:0] d0, input logic [2:0] res, votes,
                                input logic [31:0] near);
        vec_t r;
        r.lbl[0] = l0; r.lbl[1] = l1; r.lbl[2] = l2; r.lbl[3] = l3;
        r.vld = v; r.dist0 = d0; r.exp_res = res; r.exp_votes = votes; r.exp_near = near;
        return r;
    endfunction

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v);
        for (int i = 0; i < 4; i++) begin
            slot_label[i] = v.lbl[i];
            slot_valid[i] = v.vld[i];
            slot_dist[i]  = (i == 0) ? v.dist0 : 32'h100 * (i + 1);
        end
    endtask

    task automatic read(input logic [1:0] a, input logic [31:0] exp);
        valid = 1'b1; address = a; wstrb = 4'h0;
        exp_q.push_back('{addr: a, exp: exp});
        tick();
        valid = 1'b0;
        tick();
    endtask

    // Pulse start and count cycles until busy falls; optionally read and
    // re-pulse start while the scan is running.
    task automatic run_scan(input bit disturb, input logic [31:0] prev_res, output int lat);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        lat = 0;
        while (busy && lat < 100) begin
            if (disturb) begin
                case (lat)
                    1: begin
                        valid = 1'b1; address = KNN_RD_RESULT; wstrb = 4'h0;
                        exp_q.push_back('{addr: KNN_RD_RESULT, exp: prev_res});
                    end
                    2: begin
                        address = KNN_RD_STATUS;
                        exp_q.push_back('{addr: KNN_RD_STATUS, exp: 32'h2});
                    end
                    3: begin valid = 1'b0; start = 1'b1; end
                    4: start = 1'b0;
                    default: ;
                endcase
            end
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat;
        logic [31:0] prev_res;

        vecs[0] = mk(2, 5, 2, 7, 4'b1111, 32'h1A, 2, 2, 32'h1A);
        vecs[1] = mk(6, 3, 6, 3, 4'b1111, 32'h05, 3, 2, 32'h05);
        vecs[2] = mk(4, 1, 1, 1, 4'b0001, 32'h77, 4, 1, 32'h77);
        vecs[3] = mk(5, 5, 5, 5, 4'b0000, 32'h33, 0, 0, 32'hFFFF_FFFF);
        vecs[4] = mk(7, 7, 7, 7, 4'b1111, 32'h00, 7, 4, 32'h00);
        vecs[5] = mk(1, 2, 3, 0, 4'b1111, 32'h99, 0, 1, 32'h99);

        rst = 1'b1; start = 1'b0; valid = 1'b0; address = '0; wstrb = '0;
        apply(vecs[0]);
        tick(); tick();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_rdata", rdata, 32'd0);
        check("reset_nb_idx", 32'(nb_idx), 32'd0);
        rst = 1'b0;
        tick();
        read(KNN_RD_STATUS, 32'h0);

        // Reset in the middle of a scan.
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        check("mid_scan_nb_idx", 32'(nb_idx), 32'd1);
        rst = 1'b1;
        #1;
        check("async_reset_busy", 32'(busy), 32'd0);
        tick();
        check("reset_hold_busy", 32'(busy), 32'd0);
        check("reset_hold_nb_idx", 32'(nb_idx), 32'd0);
        rst = 1'b0;
        tick();
        read(KNN_RD_STATUS, 32'h0);

        prev_res = 32'h0;
        for (int i = 0; i < 6; i++) begin
            apply(vecs[i]);
            run_scan(i == 2, prev_res, lat);
            check($sformatf("latency_v%0d", i), 32'(lat), 32'd13);
            read(KNN_RD_STATUS, 32'h1);
            read(KNN_RD_RESULT, 32'(vecs[i].exp_res));
            read(KNN_RD_VOTES, 32'(vecs[i].exp_votes));
            read(KNN_RD_NEAREST, vecs[i].exp_near);
            read(KNN_RD_STATUS, 32'h0);
            prev_res = 32'(vecs[i].exp_res);
        end

        // Write transfers are not served; back-to-back reads are.
        apply(vecs[0]);
        run_scan(1'b0, prev_res, lat);
        check("latency_wr", 32'(lat), 32'd13);
        valid = 1'b1; wstrb = 4'hF; address = KNN_RD_RESULT;
        tick();
        check("write_no_ready", 32'(ready), 32'd0);
        valid = 1'b0; wstrb = 4'h0;
        tick();
        valid = 1'b1; address = KNN_RD_STATUS;
        exp_q.push_back('{addr: KNN_RD_STATUS, exp: 32'h1});
        tick();
        address = KNN_RD_RESULT;
        exp_q.push_back('{addr: KNN_RD_RESULT, exp: 32'h2});
        tick();
        valid = 1'b0;
        tick();
        read(KNN_RD_STATUS, 32'h0);

        repeat (4) tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
